image_uart_tx: RTL and testbench

Streams the downsampled image buffer back to the PC over an 8N1 UART line. It is the transmit end of the serial link whose receive side loads the source image. On `start_transmit` it reads `NUM_BYTES` bytes from the result RAM, starting at address 0, and serializes each one on `tx`. It holds `tx_busy` high for the whole transfer and pulses `tx_done` once the final stop bit completes.

---
 rtl/downsample_pkg.sv | 25 ++
 rtl/uart_tx_serializer.sv | 106 ++++++++++
 rtl/image_uart_tx.sv | 121 ++++++++++++
 tb/tb_image_uart_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/downsample_pkg.sv
// Types and UART framing constants shared by the image link's transmit and receive ends.
package downsample_pkg;

   localparam int   UART_DATA_BITS = 8;
   localparam logic UART_IDLE      = 1'b1;
   localparam logic UART_START     = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_MEM,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_DONE
   } tx_state_t;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_START,
      SER_DATA,
      SER_STOP
   } ser_phase_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer: a load pulse drives the start bit on tx from the next edge.
// Each bit is held CLKS_PER_BIT clocks and no new load is taken until the stop bit ends.
module uart_tx_serializer
   import downsample_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      load,
   input  logic [UART_DATA_BITS-1:0] byte_in,
   output logic                      tx,
   output logic                      ser_busy,
   output logic                      ser_done,
   output logic                      ser_bit_end,
   output logic                      ser_last_bit
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(UART_DATA_BITS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

   ser_phase_t                phase_q, phase_d;
   logic [BAUD_W-1:0]         baud_q, baud_d;
   logic [BIT_W-1:0]          bit_q, bit_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      tx_q, tx_d;

   assign ser_bit_end  = (baud_q == BAUD_LAST);
   assign ser_busy     = (phase_q != SER_IDLE);
   assign ser_done     = (phase_q == SER_STOP) && ser_bit_end;
   assign ser_last_bit = (phase_q == SER_DATA) && (bit_q == BIT_LAST);
   assign tx           = tx_q;

   // The baud counter reloads exactly at every bit boundary, so bit edges never drift.
   always_comb begin
      phase_d = phase_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      case (phase_q)
         SER_IDLE: begin
            tx_d = UART_IDLE;
            if (load) begin
               phase_d = SER_START;
               shift_d = byte_in;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = UART_START;
            end
         end
         SER_START: begin
            if (ser_bit_end) begin
               phase_d = SER_DATA;
               baud_d  = '0;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         SER_DATA: begin
            if (ser_bit_end) begin
               baud_d = '0;
               if (bit_q == BIT_LAST) begin
                  phase_d = SER_STOP;
                  tx_d    = UART_IDLE;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         SER_STOP: begin
            if (ser_bit_end) begin
               phase_d = SER_IDLE;
               baud_d  = '0;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: phase_d = SER_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= SER_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= UART_IDLE;
      end else begin
         phase_q <= phase_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: rtl/image_uart_tx.sv
// Streams NUM_BYTES bytes from the result RAM (address 0 upward) out as 8N1 UART frames.
// Each byte costs 10*CLKS_PER_BIT+2 clocks; start_transmit is ignored while a transfer runs.
module image_uart_tx
   import downsample_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int NUM_BYTES    = 16384,
   parameter int ADDR_W       = 14
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start_transmit,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [7:0]        mem_data,
   output logic              tx,
   output logic              tx_busy,
   output logic              tx_done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BYTES - 1);

   tx_state_t         state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_en_q, mem_rd_en_d;
   logic              tx_busy_q, tx_busy_d;
   logic              tx_done_q, tx_done_d;
   logic              load;
   logic              ser_busy, ser_done, ser_bit_end, ser_last_bit;

   assign mem_addr  = mem_addr_q;
   assign mem_rd_en = mem_rd_en_q;
   assign tx_busy   = tx_busy_q;
   assign tx_done   = tx_done_q;

   // Strobes are computed one state ahead so that they are registered yet line up with FETCH/DONE.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      mem_addr_d  = mem_addr_q;
      mem_rd_en_d = 1'b0;
      tx_busy_d   = tx_busy_q;
      tx_done_d   = 1'b0;
      load        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tx_busy_d = 1'b0;
            if (start_transmit) begin
               idx_d       = '0;
               mem_addr_d  = '0;
               mem_rd_en_d = 1'b1;
               tx_busy_d   = 1'b1;
               state_d     = ST_FETCH;
            end
         end
         ST_FETCH:    state_d = ST_WAIT_MEM;
         ST_WAIT_MEM: begin
            load    = 1'b1;
            state_d = ST_START;
         end
         ST_START: begin
            if (ser_busy && ser_bit_end) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (ser_bit_end && ser_last_bit) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (ser_done) begin
               if (idx_q == LAST_IDX) begin
                  state_d   = ST_DONE;
                  tx_done_d = 1'b1;
               end else begin
                  idx_d       = idx_q + ADDR_W'(1);
                  mem_addr_d  = idx_q + ADDR_W'(1);
                  mem_rd_en_d = 1'b1;
                  state_d     = ST_FETCH;
               end
            end
         end
         ST_DONE: begin
            tx_busy_d = 1'b0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         mem_addr_q  <= '0;
         mem_rd_en_q <= 1'b0;
         tx_busy_q   <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         mem_addr_q  <= mem_addr_d;
         mem_rd_en_q <= mem_rd_en_d;
         tx_busy_q   <= tx_busy_d;
         tx_done_q   <= tx_done_d;
      end
   end

   uart_tx_serializer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_ser (
      .clock        (clock),
      .reset_n      (reset_n),
      .load         (load),
      .byte_in      (mem_data),
      .tx           (tx),
      .ser_busy     (ser_busy),
      .ser_done     (ser_done),
      .ser_bit_end  (ser_bit_end),
      .ser_last_bit (ser_last_bit)
   );

endmodule

// File: tb/tb_image_uart_tx.sv
// Bench for image_uart_tx: three instances (single byte, three bytes, full baud rate).
module tb_image_uart_tx;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       start_v [3];
   logic [3:0] addr_w [3];
   logic       rd_w [3];
   logic       tx_w [3];
   logic       busy_w [3];
   logic       done_w [3];
   logic [7:0] md [3];
   logic [7:0] mem [3][16];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   image_uart_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(1), .ADDR_W(4)) u1 (
      .clock(clock), .reset_n(reset_n), .start_transmit(start_v[0]),
      .mem_addr(addr_w[0]), .mem_rd_en(rd_w[0]), .mem_data(md[0]),
      .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

   image_uart_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(3), .ADDR_W(4)) u3 (
      .clock(clock), .reset_n(reset_n), .start_transmit(start_v[1]),
      .mem_addr(addr_w[1]), .mem_rd_en(rd_w[1]), .mem_data(md[1]),
      .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

   image_uart_tx #(.CLKS_PER_BIT(434), .NUM_BYTES(4), .ADDR_W(4)) ub (
      .clock(clock), .reset_n(reset_n), .start_transmit(start_v[2]),
      .mem_addr(addr_w[2]), .mem_rd_en(rd_w[2]), .mem_data(md[2]),
      .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

   // Synchronous-read RAM model: data valid one clock after the read strobe.
   always @(posedge clock) begin
      for (int i = 0; i < 3; i++)
         if (rd_w[i]) md[i] <= mem[i][addr_w[i]];
   end

   typedef struct {
      int   cyc;
      logic tx;
      logic busy;
      logic done;
      logic rd;
   } vec_t;

   vec_t vt[$];

   // Results of the most recent run; cycle 0 is the cycle in which start is first sampled.
   int         c_done, n_done, n_busy, n_rd, drift_err, frame_err;
   logic [7:0] rx_q[$];
   int         addr_q[$];
   int         rdc_q[$];
   int         sof_q[$];
   logic       tr_tx [64];
   logic       tr_busy [64];
   logic       tr_done [64];
   logic       tr_rd [64];

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic void add_vec(input int c, input logic t, input logic b, input logic d, input logic r);
      vec_t v;
      v.cyc = c; v.tx = t; v.busy = b; v.done = d; v.rd = r;
      vt.push_back(v);
   endfunction

   function automatic int q8(input int i);
      return (rx_q.size() > i) ? int'(rx_q[i]) : -1;
   endfunction

   // Pulses (or holds) start on instance s, samples each negedge and decodes the UART line.
   task automatic run(input int s, input int cpb, input int max_c, input bit hold,
                      input int repulse, input bit exp_done, input int tail);
      bit         in_frame = 0;
      logic       prev = 1'b1;
      int         fstart = 0;
      int         off;
      logic [7:0] shreg = '0;
      c_done = -1; n_done = 0; n_busy = 0; n_rd = 0; drift_err = 0; frame_err = 0;
      rx_q.delete(); addr_q.delete(); rdc_q.delete(); sof_q.delete();
      for (int i = 0; i < 64; i++) begin
         tr_tx[i] = 1'b0; tr_busy[i] = 1'b0; tr_done[i] = 1'b0; tr_rd[i] = 1'b0;
      end
      @(negedge clock);
      start_v[s] = 1'b1;
      for (int c = 0; c < max_c; c++) begin
         if (c == 1 && !hold) start_v[s] = 1'b0;
         if (repulse > 0 && c == repulse) start_v[s] = 1'b1;
         else if (repulse > 0 && c == repulse + 1 && !hold) start_v[s] = 1'b0;
         if (c < 64) begin
            tr_tx[c] = tx_w[s]; tr_busy[c] = busy_w[s]; tr_done[c] = done_w[s]; tr_rd[c] = rd_w[s];
         end
         if (rd_w[s]) begin
            n_rd++; addr_q.push_back(int'(addr_w[s])); rdc_q.push_back(c);
         end
         if (busy_w[s]) n_busy++;
         if (done_w[s]) begin
            n_done++;
            if (c_done < 0) c_done = c;
         end
         if (!in_frame && prev && !tx_w[s]) begin
            in_frame = 1; fstart = c; sof_q.push_back(c);
         end else if (in_frame) begin
            off = c - fstart;
            if (tx_w[s] != prev && (off % cpb) != 0) drift_err++;
            if ((off % cpb) == cpb / 2) begin
               if (off / cpb == 0) begin
                  if (tx_w[s] !== 1'b0) frame_err++;
               end else if (off / cpb <= 8) begin
                  shreg[off / cpb - 1] = tx_w[s];
               end else begin
                  if (tx_w[s] !== 1'b1) frame_err++;
                  rx_q.push_back(shreg);
                  in_frame = 0;
               end
            end
         end
         prev = tx_w[s];
         if (n_done > 0 && c >= c_done + tail) break;
         @(negedge clock);
      end
      start_v[s] = 1'b0;
      if (exp_done && n_done == 0) chk("done_timeout", 0, 1);
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      logic [9:0] frame_a5;
      int         nd;
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         for (int j = 0; j < 16; j++) mem[i][j] = 8'h00;
      end
      mem[0][0] = 8'hA5;
      mem[1][0] = 8'h00; mem[1][1] = 8'hFF; mem[1][2] = 8'h3C;
      mem[2][0] = 8'h55; mem[2][1] = 8'hC3; mem[2][2] = 8'h01; mem[2][3] = 8'h80;

      // Single-byte 0xA5 frame: 0,1,0,1,0,0,1,0,1,1 (index 0 first), 4 clocks per bit.
      frame_a5 = 10'b1101001010;
      add_vec(0, 1'b1, 1'b0, 1'b0, 1'b0);
      add_vec(1, 1'b1, 1'b1, 1'b0, 1'b1);
      add_vec(2, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int b = 0; b < 10; b++) begin
         add_vec(3 + 4 * b, frame_a5[b], 1'b1, 1'b0, 1'b0);
         add_vec(6 + 4 * b, frame_a5[b], 1'b1, 1'b0, 1'b0);
      end
      add_vec(43, 1'b1, 1'b1, 1'b1, 1'b0);
      add_vec(44, 1'b1, 1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      for (int i = 0; i < 3; i++)
         chk($sformatf("reset_state_%0d", i),
             int'({tx_w[i], busy_w[i], done_w[i], rd_w[i], addr_w[i]}), 'h80);

      // Single byte, cycle-accurate table.
      run(0, 4, 100, 1'b0, -1, 1'b1, 2);
      foreach (vt[k])
         chk($sformatf("vec_c%0d", vt[k].cyc),
             int'({tr_tx[vt[k].cyc], tr_busy[vt[k].cyc], tr_done[vt[k].cyc], tr_rd[vt[k].cyc]}),
             int'({vt[k].tx, vt[k].busy, vt[k].done, vt[k].rd}));
      chk("single_done_cnt", n_done, 1);
      chk("single_done_cyc", c_done, 43);
      chk("single_busy_cycles", n_busy, 43);

      // Three bytes.
      run(1, 4, 300, 1'b0, -1, 1'b1, 1);
      chk("multi_nbytes", rx_q.size(), 3);
      chk("multi_byte0", q8(0), 'h00);
      chk("multi_byte1", q8(1), 'hFF);
      chk("multi_byte2", q8(2), 'h3C);
      chk("multi_rd_cnt", n_rd, 3);
      chk("multi_addrs", (addr_q.size() == 3) ? (addr_q[0] * 100 + addr_q[1] * 10 + addr_q[2]) : -1, 12);
      chk("multi_gap01", (sof_q.size() == 3) ? sof_q[1] - sof_q[0] : -1, 42);
      chk("multi_gap12", (sof_q.size() == 3) ? sof_q[2] - sof_q[1] : -1, 42);
      chk("multi_frame_err", frame_err, 0);
      chk("multi_done_cyc", c_done, 127);

      // Start re-pulsed during DATA of the first byte must be ignored.
      run(1, 4, 300, 1'b0, 20, 1'b1, 4);
      chk("ignore_done_cnt", n_done, 1);
      chk("ignore_rd_cnt", n_rd, 3);
      chk("ignore_addrs", (addr_q.size() == 3) ? (addr_q[0] * 100 + addr_q[1] * 10 + addr_q[2]) : -1, 12);
      chk("ignore_done_cyc", c_done, 127);

      // Start held high: a new transfer is accepted in the IDLE cycle after DONE.
      run(0, 4, 100, 1'b1, -1, 1'b1, 3);
      chk("held_done_cyc", c_done, 43);
      chk("held_idle_busy", int'(tr_busy[44]), 0);
      chk("held_rd2_cyc", (rdc_q.size() >= 2) ? rdc_q[1] : -1, 45);
      chk("held_rd2_addr", (addr_q.size() >= 2) ? addr_q[1] : -1, 0);
      pulse_reset();

      // Reset during DATA bit 3 (cycles 19..22).
      run(0, 4, 21, 1'b0, -1, 1'b0, 0);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_tx_busy", int'({tx_w[0], busy_w[0]}), 'h2);
      nd = 0;
      repeat (3) begin
         @(negedge clock);
         if (done_w[0]) nd++;
      end
      chk("rst_mid_no_done", nd, 0);
      reset_n = 1'b1;
      @(negedge clock);
      run(0, 4, 100, 1'b0, -1, 1'b1, 1);
      chk("rst_resend_byte", q8(0), 'hA5);
      chk("rst_resend_sof", (sof_q.size() > 0) ? sof_q[0] : -1, 3);

      // Full baud rate, four bytes.
      run(2, 434, 20000, 1'b0, -1, 1'b1, 1);
      chk("baud_nbytes", rx_q.size(), 4);
      chk("baud_bytes", (rx_q.size() == 4) ? int'({rx_q[0], rx_q[1], rx_q[2], rx_q[3]}) : -1, 'h55C30180);
      chk("baud_drift", drift_err, 0);
      chk("baud_frame_err", frame_err, 0);
      for (int i = 1; i < 4; i++)
         chk($sformatf("baud_sof_gap%0d", i), (sof_q.size() == 4) ? sof_q[i] - sof_q[i - 1] : -1, 4342);
      chk("baud_done_cyc", c_done, 1 + 4 * 4342);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
